// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Forwarding selects, stall/clear generation and memory wait FSM
//             with timeout watchdog for the 5-stage core.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter logic [1:0] LOAD_SRC    = 2'b01,
    parameter int         MEM_TIMEOUT = 1024,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic [1:0]       ex_result_src,
    input  logic             ex_pc_src,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    output logic [1:0]       ex_op1_forward,
    output logic [1:0]       ex_op2_forward,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             id_clear,
    output logic             ex_clear,
    output logic             mem_clear,
    output logic             wb_clear,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_mem_fault;

    logic       w_fault;
    logic       w_mw;
    logic       w_br;
    logic       w_lu;
    logic [1:0] w_fwd1;
    logic [1:0] w_fwd2;

    assign w_fault = (r_state == S_FAULT);
    assign w_mw    = mem_req && !mem_ready && (r_state == S_RUN || r_state == S_WAIT);
    assign w_br    = ex_pc_src;
    assign w_lu    = ex_reg_write && (ex_result_src == LOAD_SRC) && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // MEM has priority over WB since it holds the younger result; x0 never forwards
    always_comb begin
        w_fwd1 = 2'b00;
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1)
            w_fwd1 = 2'b10;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1)
            w_fwd1 = 2'b01;
    end

    always_comb begin
        w_fwd2 = 2'b00;
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2)
            w_fwd2 = 2'b10;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2)
            w_fwd2 = 2'b01;
    end

    always_comb begin
        ex_op1_forward = w_fwd1;
        ex_op2_forward = w_fwd2;
        if_stall       = 1'b0;
        id_stall       = 1'b0;
        ex_stall       = 1'b0;
        mem_stall      = 1'b0;
        id_clear       = 1'b0;
        ex_clear       = 1'b0;
        mem_clear      = 1'b0;
        wb_clear       = 1'b0;
        if (reset) begin
            ex_op1_forward = 2'b00;
            ex_op2_forward = 2'b00;
            id_clear       = 1'b1;
            ex_clear       = 1'b1;
            mem_clear      = 1'b1;
            wb_clear       = 1'b1;
        end else if (w_fault || w_mw) begin
            if (w_fault) begin
                ex_op1_forward = 2'b00;
                ex_op2_forward = 2'b00;
            end
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            ex_stall  = 1'b1;
            mem_stall = 1'b1;
            wb_clear  = 1'b1;
        end else if (w_br) begin
            id_clear = 1'b1;
            ex_clear = 1'b1;
        end else if (w_lu) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
            ex_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_wait_cnt  <= '0;
            r_mem_fault <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (if_stall && r_stall_cnt != c_cnt_max)
                r_stall_cnt <= r_stall_cnt + c_cnt_one;

            case (r_state)
                S_RUN: begin
                    r_wait_cnt <= '0;
                    if (w_mw)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ready || !mem_req) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == c_wait_last) begin
                        r_state     <= S_FAULT;
                        r_mem_fault <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_cnt_one;
                    end
                end
                S_FAULT: begin
                    r_mem_fault <= 1'b1;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign mem_fault    = r_mem_fault;
    assign stall_cycles = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Purpose  : Directed self-checking bench for hazard_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int c_cnt_w = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic ex_reg_write, ex_pc_src, mem_reg_write, mem_req, mem_ready, wb_reg_write;
    logic [1:0] ex_result_src;

    logic [1:0] ex_op1_forward, ex_op2_forward;
    logic if_stall, id_stall, ex_stall, mem_stall;
    logic id_clear, ex_clear, mem_clear, wb_clear;
    logic mem_fault;
    logic [c_cnt_w-1:0] stall_cycles;

    logic [3:0] w_stalls;
    logic [3:0] w_clears;
    assign w_stalls = {if_stall, id_stall, ex_stall, mem_stall};
    assign w_clears = {id_clear, ex_clear, mem_clear, wb_clear};

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(
        .LOAD_SRC   (2'b01),
        .MEM_TIMEOUT(4),
        .CNT_W      (c_cnt_w)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_result_src (ex_result_src),
        .ex_pc_src     (ex_pc_src),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .ex_op1_forward(ex_op1_forward),
        .ex_op2_forward(ex_op2_forward),
        .if_stall      (if_stall),
        .id_stall      (id_stall),
        .ex_stall      (ex_stall),
        .mem_stall     (mem_stall),
        .id_clear      (id_clear),
        .ex_clear      (ex_clear),
        .mem_clear     (mem_clear),
        .wb_clear      (wb_clear),
        .mem_fault     (mem_fault),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        ex_reg_write = 1'b0; ex_pc_src = 1'b0; mem_reg_write = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; wb_reg_write = 1'b0;
        ex_result_src = 2'b00;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        mem_rd = 5'd5; mem_reg_write = 1'b1; ex_rs1 = 5'd5;
        reset = 1'b1;
        #2;
        checks++;
        if (w_clears !== 4'b1111) begin
            errors++; $display("FAIL reset_clears: got %b expected %b", w_clears, 4'b1111);
        end
        checks++;
        if (w_stalls !== 4'b0000 || ex_op1_forward !== 2'b00) begin
            errors++; $display("FAIL reset_stall_fwd: got stalls %b fwd %b expected 0000 00", w_stalls, ex_op1_forward);
        end
        next_cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (stall_cycles !== 4'd0 || mem_fault !== 1'b0) begin
            errors++; $display("FAIL reset_state: got cnt %0d fault %b expected 0 0", stall_cycles, mem_fault);
        end
        checks++;
        if (w_clears !== 4'b0000 || ex_op1_forward !== 2'b10) begin
            errors++; $display("FAIL post_reset: got clears %b fwd %b expected 0000 10", w_clears, ex_op1_forward);
        end
        set_idle();
    endtask

    task automatic test_forwarding();
        set_idle();
        mem_rd = 5'd5; wb_rd = 5'd5; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        ex_rs1 = 5'd5; ex_rs2 = 5'd5;
        #1;
        checks++;
        if ({ex_op1_forward, ex_op2_forward} !== 4'b1010) begin
            errors++; $display("FAIL fwd_mem_prio: got %b expected %b", {ex_op1_forward, ex_op2_forward}, 4'b1010);
        end
        mem_reg_write = 1'b0;
        #1;
        checks++;
        if ({ex_op1_forward, ex_op2_forward} !== 4'b0101) begin
            errors++; $display("FAIL fwd_wb: got %b expected %b", {ex_op1_forward, ex_op2_forward}, 4'b0101);
        end
        mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        #1;
        checks++;
        if ({ex_op1_forward, ex_op2_forward} !== 4'b0000) begin
            errors++; $display("FAIL fwd_x0: got %b expected %b", {ex_op1_forward, ex_op2_forward}, 4'b0000);
        end
        mem_rd = 5'd7; ex_rs1 = 5'd7; wb_rd = 5'd9; ex_rs2 = 5'd9;
        #1;
        checks++;
        if ({ex_op1_forward, ex_op2_forward} !== 4'b1001) begin
            errors++; $display("FAIL fwd_split: got %b expected %b", {ex_op1_forward, ex_op2_forward}, 4'b1001);
        end
        set_idle();
    endtask

    task automatic test_load_use();
        set_idle();
        ex_rd = 5'd3; ex_result_src = 2'b01; ex_reg_write = 1'b1; id_rs2 = 5'd3;
        #1;
        checks++;
        if (w_stalls !== 4'b1100 || w_clears !== 4'b0100) begin
            errors++; $display("FAIL lu_hit: got stalls %b clears %b expected 1100 0100", w_stalls, w_clears);
        end
        next_cycle();
        // the bubble reached EX, so the hazard is gone next cycle
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_result_src = 2'b00;
        #1;
        checks++;
        if (w_stalls !== 4'b0000 || w_clears !== 4'b0000) begin
            errors++; $display("FAIL lu_one_cycle: got stalls %b clears %b expected 0000 0000", w_stalls, w_clears);
        end
        ex_rd = 5'd0; ex_result_src = 2'b01; ex_reg_write = 1'b1; id_rs2 = 5'd0;
        #1;
        checks++;
        if (w_stalls !== 4'b0000 || w_clears !== 4'b0000) begin
            errors++; $display("FAIL lu_x0: got stalls %b clears %b expected 0000 0000", w_stalls, w_clears);
        end
        ex_rd = 5'd3; id_rs1 = 5'd3; id_rs2 = 5'd0; ex_result_src = 2'b00;
        #1;
        checks++;
        if (w_stalls !== 4'b0000) begin
            errors++; $display("FAIL lu_not_load: got stalls %b expected 0000", w_stalls);
        end
        ex_result_src = 2'b01; ex_pc_src = 1'b1;
        #1;
        checks++;
        if (w_stalls !== 4'b0000 || w_clears !== 4'b1100) begin
            errors++; $display("FAIL br_over_lu: got stalls %b clears %b expected 0000 1100", w_stalls, w_clears);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_mem_wait();
        set_idle();
        pulse_reset();
        mem_req = 1'b1; mem_ready = 1'b0; ex_pc_src = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++;
            if (w_stalls !== 4'b1111 || w_clears !== 4'b0001) begin
                errors++; $display("FAIL mw_cycle%0d: got stalls %b clears %b expected 1111 0001", k, w_stalls, w_clears);
            end
            next_cycle();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (w_stalls !== 4'b0000 || w_clears !== 4'b1100) begin
            errors++; $display("FAIL mw_release: got stalls %b clears %b expected 0000 1100", w_stalls, w_clears);
        end
        checks++;
        if (stall_cycles !== 4'd3) begin
            errors++; $display("FAIL mw_count: got %0d expected 3", stall_cycles);
        end
        next_cycle();
        set_idle();
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        checks++;
        if (w_stalls !== 4'b0000 || stall_cycles !== 4'd3) begin
            errors++; $display("FAIL mw_after: got stalls %b cnt %0d expected 0000 3", w_stalls, stall_cycles);
        end
        set_idle();
    endtask

    task automatic test_timeout();
        set_idle();
        pulse_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            checks++;
            if (w_stalls !== 4'b1111 || mem_fault !== 1'b0) begin
                errors++; $display("FAIL to_wait%0d: got stalls %b fault %b expected 1111 0", k, w_stalls, mem_fault);
            end
            next_cycle();
        end
        mem_ready = 1'b1;
        mem_rd = 5'd5; mem_reg_write = 1'b1; ex_rs1 = 5'd5; ex_rs2 = 5'd5;
        #1;
        checks++;
        if (mem_fault !== 1'b1 || w_stalls !== 4'b1111 || w_clears !== 4'b0001) begin
            errors++; $display("FAIL fault_outputs: got fault %b stalls %b clears %b expected 1 1111 0001", mem_fault, w_stalls, w_clears);
        end
        checks++;
        if ({ex_op1_forward, ex_op2_forward} !== 4'b0000 || stall_cycles !== 4'd5) begin
            errors++; $display("FAIL fault_fwd_cnt: got fwd %b cnt %0d expected 0000 5", {ex_op1_forward, ex_op2_forward}, stall_cycles);
        end
        repeat (12) next_cycle();
        checks++;
        if (mem_fault !== 1'b1 || stall_cycles !== 4'd15) begin
            errors++; $display("FAIL fault_sticky_sat: got fault %b cnt %0d expected 1 15", mem_fault, stall_cycles);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (w_clears !== 4'b1111 || w_stalls !== 4'b0000) begin
            errors++; $display("FAIL fault_reset_hold: got clears %b stalls %b expected 1111 0000", w_clears, w_stalls);
        end
        next_cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (mem_fault !== 1'b0 || stall_cycles !== 4'd0 || w_stalls !== 4'b0000) begin
            errors++; $display("FAIL fault_cleared: got fault %b cnt %0d stalls %b expected 0 0 0000", mem_fault, stall_cycles, w_stalls);
        end
        set_idle();
    endtask

    task automatic test_reset_mid_wait();
        set_idle();
        pulse_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        #1;
        checks++;
        if (w_clears !== 4'b1111 || w_stalls !== 4'b0000) begin
            errors++; $display("FAIL wait_reset_hold: got clears %b stalls %b expected 1111 0000", w_clears, w_stalls);
        end
        next_cycle();
        reset = 1'b0;
        mem_req = 1'b0;
        #1;
        checks++;
        if (stall_cycles !== 4'd0 || w_stalls !== 4'b0000 || mem_fault !== 1'b0) begin
            errors++; $display("FAIL wait_reset_state: got cnt %0d stalls %b fault %b expected 0 0000 0", stall_cycles, w_stalls, mem_fault);
        end
        // a fresh wait must get the full timeout window again
        mem_req = 1'b1;
        repeat (4) next_cycle();
        checks++;
        if (mem_fault !== 1'b0 || w_stalls !== 4'b1111) begin
            errors++; $display("FAIL wait_restart: got fault %b stalls %b expected 0 1111", mem_fault, w_stalls);
        end
        set_idle();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
